// File: rtl/epu_pkg.sv
// Shared types and defaults for the EPU buffer read-port arbiter.
package epu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam int EPU_NREQ      = 2;
    localparam int EPU_BLOCK_NUM = 64;
    localparam int EPU_BURST     = 16;
    localparam int EPU_ADDR_W    = 12;
    localparam int EPU_DATA_W    = 128;

endpackage

// File: rtl/epu_rr_arb.sv
// Winner select for the EPU buffer port: round-robin from rr_ptr_i, or fixed priority
// (requester 0 highest) when EPU_ARB_FIXED_PRIO_EN is defined.
// Purely combinational; no backpressure, the caller samples the result only in IDLE.
module epu_rr_arb
    import epu_pkg::*;
#(
    parameter int NREQ  = EPU_NREQ,
    parameter int PTR_W = $clog2(EPU_NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] rr_ptr_i,
    output logic             win_vld_o,
    output logic [PTR_W-1:0] win_idx_o,
    output logic [NREQ-1:0]  win_oh_o
);

    always_comb begin
        int cand;
        cand      = 0;
        win_vld_o = 1'b0;
        win_idx_o = '0;
        win_oh_o  = '0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef EPU_ARB_FIXED_PRIO_EN
            cand = i;
`else
            cand = (int'(rr_ptr_i) + i) % NREQ;
`endif
            if (!win_vld_o && req_i[cand]) begin
                win_vld_o      = 1'b1;
                win_idx_o      = PTR_W'(cand);
                win_oh_o[cand] = 1'b1;
            end
        end
    end

`ifdef EPU_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^rr_ptr_i;
`endif

endmodule

// File: rtl/epu_buf_arb.sv
// Shares the EPU buffer read port: one 16-beat block burst per grant, owner picked in IDLE
// (round-robin, or fixed priority under EPU_ARB_FIXED_PRIO_EN). Beats start 1 cycle after grant,
// rvalid trails mem_read by 1; losers simply wait with req held, bursts are never aborted.
module epu_buf_arb
    import epu_pkg::*;
#(
    parameter int NREQ      = EPU_NREQ,
    parameter int BLOCK_NUM = EPU_BLOCK_NUM,
    parameter int BURST     = EPU_BURST,
    parameter int ADDR_W    = EPU_ADDR_W,
    parameter int DATA_W    = EPU_DATA_W
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NREQ-1:0]                     req_i,
    input  logic [NREQ*$clog2(BLOCK_NUM)-1:0]   req_blk_i,
    output logic [NREQ-1:0]                     gnt_o,
    output logic [NREQ-1:0]                     rvalid_o,
    output logic [DATA_W-1:0]                   rdata_o,
    output logic [NREQ-1:0]                     done_o,
    output logic                                mem_read_o,
    output logic [ADDR_W-1:0]                   mem_addr_o,
    input  logic [DATA_W-1:0]                   mem_rdata_i
);

    localparam int BLK_W  = $clog2(BLOCK_NUM);
    localparam int PTR_W  = $clog2(NREQ);
    localparam int BEAT_W = $clog2(BURST);

    if (BLOCK_NUM * BURST > 2 ** ADDR_W) begin : g_cfg_err
        $error("epu_buf_arb: BLOCK_NUM*BURST exceeds the buffer address space");
    end

    arb_state_e        state_q;
    logic [PTR_W-1:0]  owner_q;
    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  rr_ptr_d;
    logic [BLK_W-1:0]  blk_q;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_d;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   rvalid_q;
    logic [NREQ-1:0]   done_q;
    logic              mem_read_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] base_d;

    logic              win_vld;
    logic [PTR_W-1:0]  win_idx;
    logic [NREQ-1:0]   win_oh;
    logic [BLK_W-1:0]  win_blk;
    logic              last_beat;

    epu_rr_arb #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arb (
        .req_i     (req_i),
        .rr_ptr_i  (rr_ptr_q),
        .win_vld_o (win_vld),
        .win_idx_o (win_idx),
        .win_oh_o  (win_oh)
    );

    assign win_blk   = req_blk_i[win_idx*BLK_W +: BLK_W];
    assign base_d    = ADDR_W'(win_blk) * ADDR_W'(BURST);
    assign beat_d    = beat_q + 1'b1;
    assign addr_d    = ADDR_W'(blk_q) * ADDR_W'(BURST) + ADDR_W'(beat_d);
    assign last_beat = (beat_q == BEAT_W'(BURST - 1));

`ifdef EPU_ARB_FIXED_PRIO_EN
    assign rr_ptr_d = '0;
`else
    assign rr_ptr_d = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= epu_pkg::IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            blk_q      <= '0;
            beat_q     <= '0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            done_q     <= '0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            // Read data lands one cycle after each strobe, so rvalid is the strobe delayed.
            rvalid_q <= mem_read_q ? gnt_q : '0;
            done_q   <= '0;
            case (state_q)
                epu_pkg::IDLE: begin
                    if (win_vld) begin
                        state_q    <= epu_pkg::BURST;
                        owner_q    <= win_idx;
                        blk_q      <= win_blk;
                        beat_q     <= '0;
                        gnt_q      <= win_oh;
                        mem_read_q <= 1'b1;
                        mem_addr_q <= base_d;
                    end
                end
                epu_pkg::BURST: begin
                    if (last_beat) begin
                        state_q    <= epu_pkg::DRAIN;
                        mem_read_q <= 1'b0;
                        done_q     <= gnt_q;
                        rr_ptr_q   <= rr_ptr_d;
                    end else begin
                        beat_q     <= beat_d;
                        mem_addr_q <= addr_d;
                    end
                end
                epu_pkg::DRAIN: begin
                    state_q <= epu_pkg::IDLE;
                    gnt_q   <= '0;
                end
                default: begin
                    state_q <= epu_pkg::IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt_o      = gnt_q;
    assign rvalid_o   = rvalid_q;
    assign done_o     = done_q;
    assign mem_read_o = mem_read_q;
    assign mem_addr_o = mem_addr_q;
    assign rdata_o    = mem_rdata_i;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni && state_q == epu_pkg::IDLE && win_vld) begin
            assert (32'(win_blk) < BLOCK_NUM)
            else $error("epu_buf_arb: req_blk %0d out of range", win_blk);
        end
    end
`endif

endmodule
